// File: rtl/nabp_shifter_pkg.sv
// Shared constants and state encoding for the projection line sequencer.
// Mapper, line buffer and shifter all take their sizes from here.
package nabp_shifter_pkg;

    localparam int kNumShifts  = 128;
    localparam int kRamLatency = 2;

    typedef enum logic [2:0] {
        ready_s = 3'd0,
        kick_s  = 3'd1,
        shift_s = 3'd2,
        drain_s = 3'd3,
        done_s  = 3'd4
    } shifter_states;

endpackage

// File: rtl/nabp_delay_line.sv
// Fixed-depth 1-bit register delay line with synchronous active-low clear.
// Aligns the PE-column shift enable with line-buffer read data.
module nabp_delay_line #(
    parameter int kDepth = nabp_shifter_pkg::kRamLatency
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    import nabp_shifter_pkg::*;

    logic [kDepth-1:0] r_pipe;

    generate
        if (kDepth == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!reset_n) r_pipe <= '0;
                else          r_pipe <= i_d;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!reset_n) r_pipe <= '0;
                else          r_pipe <= {r_pipe[kDepth-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_pipe[kDepth-1];

endmodule

// File: rtl/nabp_shifter.sv
// Per-line sequencer: kick the mapper, issue kNumShifts stallable shift
// enables, drain the read pipeline, then pulse done.
//
// state   | meaning
// ready_s | idle, accepts sc_kick
// kick_s  | one-cycle mapper accumulator load
// shift_s | shift enable = !pe_stall, counting enabled cycles
// drain_s | read pipeline flush, kRamLatency cycles
// done_s  | one-cycle line completion pulse
module nabp_shifter #(
    parameter int kNumShifts  = nabp_shifter_pkg::kNumShifts,
    parameter int kRamLatency = nabp_shifter_pkg::kRamLatency
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sc_kick,
    input  logic pe_stall,
    output logic sh_ready,
    output logic sh_kick,
    output logic sh_shift_en,
    output logic sh_done,
    output logic pe_shift_en
);
    import nabp_shifter_pkg::*;

    localparam int SW = $clog2(kNumShifts + 1);
    localparam int DW = $clog2(kRamLatency + 1);

    shifter_states r_state, w_next;
    logic [SW-1:0] r_shift_cnt, w_shift_nxt;
    logic [DW-1:0] r_drain_cnt, w_drain_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ready_s;
            r_shift_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_shift_cnt <= w_shift_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_shift_nxt = r_shift_cnt;
        w_drain_nxt = r_drain_cnt;
        sh_ready    = 1'b0;
        sh_kick     = 1'b0;
        sh_shift_en = 1'b0;
        sh_done     = 1'b0;
        case (r_state)
            ready_s: begin
                sh_ready = 1'b1;
                if (sc_kick) begin
                    w_next      = kick_s;
                    w_shift_nxt = '0;
                end
            end
            kick_s: begin
                sh_kick = 1'b1;
                w_next  = shift_s;
            end
            shift_s: begin
                sh_shift_en = !pe_stall;
                if (!pe_stall) begin
                    w_shift_nxt = r_shift_cnt + 1'b1;
                    if (r_shift_cnt == SW'(kNumShifts - 1)) begin
                        w_next      = drain_s;
                        w_drain_nxt = DW'(kRamLatency - 1);
                    end
                end
            end
            drain_s: begin
                if (r_drain_cnt == '0) w_next = done_s;
                else                   w_drain_nxt = r_drain_cnt - 1'b1;
            end
            done_s: begin
                sh_done = 1'b1;
                w_next  = ready_s;
            end
            default: w_next = ready_s;
        endcase
    end

    // Data addressed during a shift cycle arrives kRamLatency cycles later.
    nabp_delay_line #(.kDepth(kRamLatency)) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (sh_shift_en),
        .o_q     (pe_shift_en)
    );

endmodule
